// File: rtl/asym_fifo.sv
// Asymmetric-width FIFO: each write packs W_RATIO words (MSB word first),
// each read pops one DATA_WIDTH word from a show-ahead head.
module asym_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int W_RATIO    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr,
  input  logic [W_RATIO*DATA_WIDTH-1:0] w_data,
  input  logic                          rd,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic                          empty,
  output logic                          full,
  output logic [ADDR_WIDTH:0]           count,
  output logic                          wr_err,
  output logic                          rd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_THR = (ADDR_WIDTH+1)'(DEPTH - W_RATIO);
  localparam logic [ADDR_WIDTH:0]   CNT_INC  = (ADDR_WIDTH+1)'(W_RATIO);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_INC  = ADDR_WIDTH'(W_RATIO);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  wacc;
  logic                  racc;

  // Flags come only from the registered count, so same-cycle requests never gate each other.
  assign empty  = (count == '0);
  assign full   = (count > FULL_THR);
  assign wacc   = wr & ~full;
  assign racc   = rd & ~empty;
  assign r_data = empty ? '0 : mem[r_ptr];

  // w_ptr stays a multiple of W_RATIO, so w_ptr + k never crosses the wrap.
  always_ff @(posedge clk) begin
    if (wacc) begin
      for (int k = 0; k < W_RATIO; k++) begin
        mem[w_ptr + ADDR_WIDTH'(k)] <= w_data[(W_RATIO-k)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      count  <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (wacc) w_ptr <= w_ptr + PTR_INC;
      if (racc) r_ptr <= r_ptr + 1'b1;
      count  <= count + (wacc ? CNT_INC : '0) - (racc ? CNT_ONE : '0);
      wr_err <= wr & full;
      rd_err <= rd & empty;
    end
  end

endmodule

// File: tb/tb_asym_fifo.sv
// Scoreboard bench for asym_fifo (depth 4, 2:1): directed stimulus pushes
// expected bytes, a negedge monitor checks every accepted pop.
module tb_asym_fifo;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [15:0] w_data;
  logic        rd;
  logic [7:0]  r_data;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        wr_err;
  logic        rd_err;

  asym_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .W_RATIO(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .r_data (r_data),
    .empty  (empty),
    .full   (full),
    .count  (count),
    .wr_err (wr_err),
    .rd_err (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_cnt    = 0;
  int         n_pops   = 0;
  logic [7:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words are pushed when the bench's own occupancy says the write is accepted.
  task automatic step(input logic w, input logic [15:0] d, input logic r);
    bit full_m, empty_m;
    full_m  = (m_cnt > 2);
    empty_m = (m_cnt == 0);
    wr = w; w_data = d; rd = r;
    if (w && !full_m) begin
      sb.push_back(d[15:8]);
      sb.push_back(d[7:0]);
      m_cnt += 2;
    end
    if (r && !empty_m) m_cnt -= 1;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; w_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    m_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: mid-cycle, a request to pop a non-empty FIFO must show the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && rd && !empty) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", r_data, $time);
      end else begin
        chk("pop_data", int'(r_data), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_rd_err", rd_err, 0);

    // Basic order
    step(1, 16'hABCD, 0);
    chk("basic_count", count, 2);
    chk("basic_empty", empty, 0);
    chk("basic_head", r_data, 8'hAB);
    step(0, 0, 1);
    chk("basic_head2", r_data, 8'hCD);
    chk("basic_count2", count, 1);
    step(0, 0, 1);
    chk("basic_empty2", empty, 1);
    chk("basic_rdata0", r_data, 0);

    // Full and overflow
    step(1, 16'h1234, 0);
    step(1, 16'h5678, 0);
    chk("full_flag", full, 1);
    chk("full_count", count, 4);
    step(1, 16'h9ABC, 0);
    chk("ovf_wr_err", wr_err, 1);
    chk("ovf_count", count, 4);
    step(0, 0, 0);
    chk("ovf_wr_err_clr", wr_err, 0);
    repeat (4) step(0, 0, 1);
    chk("ovf_drain_empty", empty, 1);

    // Simultaneous access
    step(1, 16'h1234, 0);
    step(1, 16'h5678, 0);
    step(1, 16'hAAAA, 1);
    chk("sim_full_count", count, 3);
    chk("sim_full_wr_err", wr_err, 1);
    step(0, 0, 1);
    chk("sim_count2", count, 2);
    step(1, 16'hBBCC, 1);
    chk("sim_both_count", count, 3);
    chk("sim_both_wr_err", wr_err, 0);
    chk("sim_head", r_data, 8'h78);
    repeat (3) step(0, 0, 1);
    chk("sim_drain_empty", empty, 1);

    // Underflow
    do_reset();
    step(0, 0, 1);
    chk("udf_rd_err", rd_err, 1);
    chk("udf_count", count, 0);
    chk("udf_empty", empty, 1);
    chk("udf_rdata", r_data, 0);
    step(0, 0, 0);
    chk("udf_rd_err_clr", rd_err, 0);

    // Wrap-around: bytes 00..0F through the pointers several times
    n_pops = 0;
    step(1, 16'h0001, 0);
    step(1, 16'h0203, 0);
    for (int i = 2; i < 8; i++) begin
      step(0, 0, 1);
      step(0, 0, 1);
      step(1, {8'(2*i), 8'(2*i+1)}, 0);
      chk("wrap_count", count, 4);
    end
    repeat (4) step(0, 0, 1);
    chk("wrap_pops", n_pops, 16);
    chk("wrap_empty", empty, 1);

    // Asynchronous reset mid-cycle
    step(1, 16'h1234, 0);
    step(1, 16'h5678, 0);
    step(0, 0, 1);
    chk("ar_pre_count", count, 3);
    #2 reset = 1'b1;
    sb.delete();
    m_cnt = 0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_rdata", r_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 16'hABCD, 0);
    chk("ar_post_count", count, 2);
    chk("ar_post_head", r_data, 8'hAB);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("ar_post_empty", empty, 1);
    chk("sb_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
